// File: rtl/peripheral.sv
// rtl/peripheral.sv - bus peripheral: reload timer, LED/switch/digit registers, 8N1 UART
module peripheral #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic        reset,
    input  logic        clk,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  led,
    input  logic [7:0]  switch,
    output logic [11:0] digi,
    output logic        irqout,
    input  logic        PC_Uart_rxd,
    output logic        PC_Uart_txd
);

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_SW   = 32'h4000_0010;
    localparam logic [31:0] A_DIGI = 32'h4000_0014;
    localparam logic [31:0] A_TXD  = 32'h4000_0018;
    localparam logic [31:0] A_RXD  = 32'h4000_001C;
    localparam logic [31:0] A_UCON = 32'h4000_0020;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int          CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [31:0]   r_th;
    logic [31:0]   r_tl;
    logic [2:0]    r_tcon;
    logic [7:0]    r_led;
    logic [11:0]   r_digi;

    logic [1:0]    r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_data;
    logic [7:0]    r_tx_shift;
    logic          r_txd;

    logic          r_rx_s1;
    logic          r_rx_s2;
    logic          r_rx_prev;
    logic [1:0]    r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_rxd;
    logic          r_rx_valid;
    logic          r_rx_ferr;

    logic w_tx_busy;
    logic w_tx_start;
    logic w_tx_tick;
    logic w_rx_tick;
    logic w_rx_good;

    assign w_tx_busy  = (r_tx_state != ST_IDLE);
    assign w_tx_start = wr && (addr == A_TXD) && !w_tx_busy;
    assign w_tx_tick  = (r_tx_cnt == BIT_LAST);
    assign w_rx_tick  = (r_rx_cnt == BIT_LAST);
    assign w_rx_good  = (r_rx_state == ST_STOP) && w_rx_tick && r_rx_s2;

    assign led         = r_led;
    assign digi        = r_digi;
    assign irqout      = r_tcon[1] & r_tcon[2];
    assign PC_Uart_txd = r_txd;

    always_comb begin
        rdata = 32'd0;
        if (rd) begin
            case (addr)
                A_TH:    rdata = r_th;
                A_TL:    rdata = r_tl;
                A_TCON:  rdata = {29'd0, r_tcon};
                A_LED:   rdata = {24'd0, r_led};
                A_SW:    rdata = {24'd0, switch};
                A_DIGI:  rdata = {20'd0, r_digi};
                A_TXD:   rdata = {24'd0, r_tx_data};
                A_RXD:   rdata = {24'd0, r_rxd};
                A_UCON:  rdata = {29'd0, r_rx_ferr, r_rx_valid, w_tx_busy};
                default: rdata = 32'd0;
            endcase
        end
    end

    // Bus writes come last so they override the same-cycle timer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_th   <= 32'd0;
            r_tl   <= 32'd0;
            r_tcon <= 3'd0;
            r_led  <= 8'd0;
            r_digi <= 12'd0;
        end else begin
            if (r_tcon[0]) begin
                if (r_tl == 32'hFFFF_FFFF) begin
                    r_tl <= r_th;
                    if (r_tcon[1]) r_tcon[2] <= 1'b1;
                end else begin
                    r_tl <= r_tl + 32'd1;
                end
            end
            if (wr) begin
                case (addr)
                    A_TH:    r_th   <= wdata;
                    A_TL:    r_tl   <= wdata;
                    A_TCON:  r_tcon <= wdata[2:0];
                    A_LED:   r_led  <= wdata[7:0];
                    A_DIGI:  r_digi <= wdata[11:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_data  <= 8'd0;
            r_tx_shift <= 8'd0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_cnt <= w_tx_tick ? '0 : r_tx_cnt + CW'(1);
            case (r_tx_state)
                ST_IDLE: begin
                    r_txd    <= 1'b1;
                    r_tx_cnt <= '0;
                    if (w_tx_start) begin
                        r_tx_data  <= wdata[7:0];
                        r_tx_state <= ST_START;
                        r_txd      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tx_tick) begin
                        r_tx_state <= ST_DATA;
                        r_tx_bit   <= 3'd0;
                        r_txd      <= r_tx_data[0];
                        r_tx_shift <= {1'b0, r_tx_data[7:1]};
                    end
                end
                ST_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_bit   <= r_tx_bit + 3'd1;
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= ST_STOP;
                            r_txd      <= 1'b1;
                        end else begin
                            r_txd <= r_tx_shift[0];
                        end
                    end
                end
                default: begin
                    r_txd <= 1'b1;
                    if (w_tx_tick) r_tx_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The start state counts only half a bit, so every later tick lands on a bit centre.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
            r_rxd      <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_s1   <= PC_Uart_rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_rx_cnt  <= w_rx_tick ? '0 : r_rx_cnt + CW'(1);
            if (rd && (addr == A_RXD)) r_rx_valid <= 1'b0;
            case (r_rx_state)
                ST_IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rx_prev && !r_rx_s2) r_rx_state <= ST_START;
                end
                ST_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= 3'd0;
                        r_rx_state <= r_rx_s2 ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) r_rx_state <= ST_STOP;
                    end
                end
                default: begin
                    if (w_rx_tick) begin
                        r_rx_state <= ST_IDLE;
                        if (w_rx_good) begin
                            r_rxd      <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                            r_rx_ferr  <= 1'b0;
                        end else begin
                            r_rx_ferr <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral.sv
// tb/tb_peripheral.sv - randomized self-checking bench for peripheral
module tb_peripheral;

    localparam int CPB = 16;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        reset, clk, rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  led, switch;
    logic [11:0] digi;
    logic        irqout, rxd, txd;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state for the UART receiver
    logic [7:0] m_rxd;
    logic       m_valid, m_ferr;

    peripheral #(.CLKS_PER_BIT(CPB)) dut (
        .reset(reset), .clk(clk), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .led(led), .switch(switch), .digi(digi), .irqout(irqout),
        .PC_Uart_rxd(rxd), .PC_Uart_txd(txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = frame[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (6) @(negedge clk);
        if (stop) begin
            m_rxd = b; m_valid = 1'b1; m_ferr = 1'b0;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic check_rx(input bit do_read);
        logic [31:0] v;
        bus_read(BASE + 32'h20, v);
        check("uart_con", v, {29'd0, m_ferr, m_valid, 1'b0});
        if (do_read) begin
            bus_read(BASE + 32'h1C, v);
            check("uart_rxd", v, {24'd0, m_rxd});
            m_valid = 1'b0;
            bus_read(BASE + 32'h20, v);
            check("uart_con_after_read", v, {29'd0, m_ferr, m_valid, 1'b0});
        end
    endtask

    task automatic tx_frame(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        bus_write(BASE + 32'h18, {24'd0, b});
        bus_write(BASE + 32'h18, {24'd0, ~b});
        addr = BASE + 32'h20; rd = 1'b1;
        repeat (CPB / 2 - 1) @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("txd_bit%0d", k), {31'd0, txd}, {31'd0, frame[k]});
            check("tx_busy", rdata, 32'd1);
            repeat (CPB) @(posedge clk);
        end
        repeat (CPB / 2 + 2) @(posedge clk);
        #1;
        check("tx_idle_busy", rdata, 32'd0);
        check("tx_idle_txd", {31'd0, txd}, 32'd1);
        @(negedge clk);
        rd = 1'b0;
    endtask

    // Timer reference: TL starts n steps below all-ones, runs m cycles, th leaves room.
    task automatic timer_case(input logic [31:0] th, input int n, input int m, input bit ie);
        logic [31:0] tl0, exp_tl;
        bit wrapped;
        tl0 = 32'hFFFF_FFFF - n;
        wrapped = (m > n);
        exp_tl = wrapped ? th + 32'(m - n - 1) : tl0 + 32'(m);
        bus_write(BASE + 32'h8, 32'd0);
        bus_write(BASE + 32'h0, th);
        bus_write(BASE + 32'h4, tl0);
        bus_write(BASE + 32'h8, {30'd0, ie, 1'b1});
        addr = BASE + 32'h4; rd = 1'b1;
        repeat (m) @(posedge clk);
        #1;
        check("timer_tl", rdata, exp_tl);
        check("timer_irq", {31'd0, irqout}, {31'd0, ie & wrapped});
        addr = BASE + 32'h8;
        #1;
        check("timer_tcon", rdata, {29'd0, ie & wrapped, ie, 1'b1});
        @(negedge clk);
        rd = 1'b0;
    endtask

    initial begin
        logic [31:0] v, d;
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        rxd = 1'b1; switch = 8'($urandom);
        m_rxd = 8'd0; m_valid = 1'b0; m_ferr = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            bus_read(BASE + 32'(4 * i), v);
            check($sformatf("reset_reg%0d", i), v, (i == 4) ? {24'd0, switch} : 32'd0);
        end
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_irq", {31'd0, irqout}, 32'd0);

        tx_frame(8'h2D);
        for (int i = 0; i < 3; i++) tx_frame(8'($urandom));

        send_rx(8'h4D, 1'b1);
        check_rx(1'b1);
        send_rx(8'($urandom), 1'b0);
        check_rx(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_rx(8'($urandom), ($urandom_range(0, 3) != 0));
            check_rx($urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rxd = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rxd = 1'b1;
            repeat (2 * CPB) @(negedge clk);
            check_rx(1'b0);
        end

        timer_case(32'hFFFF_FFF0, 1, 2, 1'b1);
        bus_write(BASE + 32'h8, 32'd3);
        #1 check("irq_cleared", {31'd0, irqout}, 32'd0);
        for (int i = 0; i < 8; i++)
            timer_case($urandom_range(0, 32'h7FFF_FFFF), $urandom_range(0, 20),
                       $urandom_range(1, 40), $urandom_range(0, 1) == 1);
        bus_write(BASE + 32'h8, 32'd0);

        bus_write(BASE + 32'hC, 32'h0000_00A5);
        bus_write(BASE + 32'h14, 32'h0000_03F7);
        check("led", {24'd0, led}, 32'hA5);
        check("digi", {20'd0, digi}, 32'h3F7);
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            bus_write(BASE + 32'hC, d);
            bus_write(BASE + 32'h14, d);
            bus_write(BASE + 32'h10, ~d);
            switch = 8'($urandom);
            bus_read(BASE + 32'hC, v);  check("led_rd", v, {24'd0, d[7:0]});
            bus_read(BASE + 32'h14, v); check("digi_rd", v, {20'd0, d[11:0]});
            bus_read(BASE + 32'h10, v); check("switch_rd", v, {24'd0, switch});
        end
        @(negedge clk);
        addr = BASE + 32'hC; rd = 1'b0;
        #1 check("rd_low", rdata, 32'd0);
        bus_read(BASE + 32'h24, v);
        check("unmapped", v, 32'd0);

        bus_write(BASE + 32'h18, 32'h0000_0000);
        repeat (3 * CPB) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_txd", {31'd0, txd}, 32'd1);
        bus_read(BASE + 32'h20, v);
        check("reset_mid_con", v, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
